// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start/data/parity/stop and drives the line-mux select.
// Optional UART_TX_DOUBLE_BUFFER_EN adds a one-word holding register and o_buf_full.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic [1:0]            o_sel,
    output logic                  o_ser_bit,
    output logic                  o_par_bit,
    output logic                  o_busy,
`ifdef UART_TX_DOUBLE_BUFFER_EN
    output logic                  o_buf_full,
`endif
    output logic [2:0]            o_state
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  load;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_par_type;
    logic                  ld_par_en;
    logic [1:0]            sel_d;
    logic                  ser_d;
    logic                  par_d;
    logic                  busy_d;

    // Handshake: i_data_valid has no ready partner. A word is taken when valid is
    // high on an edge where the controller can accept it (IDLE or STOP, or any busy
    // state with an empty holding register in the buffered build); otherwise the
    // request is dropped, so a producer holds valid until the launch shows on o_sel.

`ifdef UART_TX_DOUBLE_BUFFER_EN
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_par_en_q;
    logic                  hold_par_type_q;
    logic                  hold_full_q;
    logic                  hold_wr;

    assign hold_wr = i_data_valid && !hold_full_q &&
                     (state_q == ST_START || state_q == ST_DATA || state_q == ST_PARITY);
    assign o_buf_full = hold_full_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_data_q     <= '0;
            hold_par_en_q   <= 1'b0;
            hold_par_type_q <= 1'b0;
            hold_full_q     <= 1'b0;
        end else if (state_q == ST_STOP && hold_full_q) begin
            hold_full_q <= 1'b0;
        end else if (hold_wr) begin
            hold_data_q     <= i_data;
            hold_par_en_q   <= i_par_en;
            hold_par_type_q <= i_par_type;
            hold_full_q     <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        ld_data     = i_data;
        ld_par_en   = i_par_en;
        ld_par_type = i_par_type;
        case (state_q)
            ST_IDLE: begin
                if (i_data_valid) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
`ifdef UART_TX_DOUBLE_BUFFER_EN
                if (hold_full_q) begin
                    state_d     = ST_START;
                    load        = 1'b1;
                    ld_data     = hold_data_q;
                    ld_par_en   = hold_par_en_q;
                    ld_par_type = hold_par_type_q;
                end else
`endif
                if (i_data_valid) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  sel_d = SEL_START;
            ST_DATA:   sel_d = SEL_DATA;
            ST_PARITY: sel_d = SEL_PARITY;
            default:   sel_d = SEL_STOP;
        endcase
        // data_q is already the latched word by the time DATA is entered.
        ser_d  = (state_d == ST_DATA) ? data_q[cnt_d] : 1'b0;
        par_d  = load ? ((^ld_data) ^ ld_par_type) : o_par_bit;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            o_sel     <= SEL_STOP;
            o_ser_bit <= 1'b0;
            o_par_bit <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if (load) begin
                data_q   <= ld_data;
                par_en_q <= ld_par_en;
            end
            o_sel     <= sel_d;
            o_ser_bit <= ser_d;
            o_par_bit <= par_d;
            o_busy    <= busy_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame shapes, parity, back-to-back, reset abort,
// input stability and (with UART_TX_DOUBLE_BUFFER_EN) the holding register.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data = '0;
    logic         valid = 1'b0;
    logic         par_en = 1'b0;
    logic         par_type = 1'b0;
    logic [1:0]   sel;
    logic         ser_bit;
    logic         par_bit;
    logic         busy;
    logic [2:0]   state;
`ifdef UART_TX_DOUBLE_BUFFER_EN
    logic         buf_full;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_data_valid (valid),
        .i_par_en     (par_en),
        .i_par_type   (par_type),
        .o_sel        (sel),
        .o_ser_bit    (ser_bit),
        .o_par_bit    (par_bit),
        .o_busy       (busy),
`ifdef UART_TX_DOUBLE_BUFFER_EN
        .o_buf_full   (buf_full),
`endif
        .o_state      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge and check every registered output.
    task automatic expect_cycle(input string tag, input logic [1:0] e_sel, input logic e_ser,
                                input logic e_par, input logic e_busy);
        logic [2:0] e_state;
        @(negedge clk);
        case (e_sel)
            2'b00:   e_state = 3'd1;
            2'b01:   e_state = 3'd2;
            2'b10:   e_state = 3'd3;
            default: e_state = e_busy ? 3'd4 : 3'd0;
        endcase
        check({tag, ".sel"}, 32'(sel), 32'(e_sel));
        check({tag, ".ser"}, 32'(ser_bit), 32'(e_ser));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".state"}, 32'(state), 32'(e_state));
        if (e_busy) check({tag, ".par"}, 32'(par_bit), 32'(e_par));
    endtask

    task automatic data_bits(input string tag, input logic [W-1:0] word, input logic e_par);
        for (int i = 0; i < W; i++) expect_cycle(tag, 2'b01, word[i], e_par, 1'b1);
    endtask

    // Single valid pulse from IDLE, full frame, then one idle cycle.
    task automatic run_frame(input string tag, input logic [W-1:0] word, input logic pe,
                             input logic pt, input logic e_par);
        data = word; par_en = pe; par_type = pt; valid = 1'b1;
        expect_cycle({tag, ".start"}, 2'b00, 1'b0, e_par, 1'b1);
        valid = 1'b0;
        data_bits({tag, ".data"}, word, e_par);
        if (pe) expect_cycle({tag, ".parity"}, 2'b10, 1'b0, e_par, 1'b1);
        expect_cycle({tag, ".stop"}, 2'b11, 1'b0, e_par, 1'b1);
        expect_cycle({tag, ".idle"}, 2'b11, 1'b0, e_par, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst.sel", 32'(sel), 32'h3);
        check("rst.ser", 32'(ser_bit), 32'h0);
        check("rst.par", 32'(par_bit), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.state", 32'(state), 32'h0);
`ifdef UART_TX_DOUBLE_BUFFER_EN
        check("rst.buf_full", 32'(buf_full), 32'h0);
`endif
        rst_n = 1'b1;
        expect_cycle("post_rst", 2'b11, 1'b0, 1'b0, 1'b0);

        // A5 has four ones: even parity 0, parity slot present, 11 busy cycles.
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0);
        // 01 odd: XOR 1 inverted gives 0; no parity slot, 10 busy cycles.
        run_frame("01_odd_nopar", 8'h01, 1'b0, 1'b1, 1'b0);
        // 03 odd: XOR 0 inverted gives 1.
        run_frame("03_odd", 8'h03, 1'b1, 1'b1, 1'b1);
        // 80 even without parity slot: XOR 1.
        run_frame("80_even_nopar", 8'h80, 1'b0, 1'b0, 1'b1);

        // Back-to-back: valid held through the first frame, second launches from STOP.
        data = 8'h3C; par_en = 1'b1; par_type = 1'b0; valid = 1'b1;
        expect_cycle("b2b.start1", 2'b00, 1'b0, 1'b0, 1'b1);
        data = 8'hC3;
        data_bits("b2b.data1", 8'h3C, 1'b0);
        expect_cycle("b2b.parity1", 2'b10, 1'b0, 1'b0, 1'b1);
        expect_cycle("b2b.stop1", 2'b11, 1'b0, 1'b0, 1'b1);
        expect_cycle("b2b.start2", 2'b00, 1'b0, 1'b0, 1'b1);
        valid = 1'b0;
        data_bits("b2b.data2", 8'hC3, 1'b0);
        expect_cycle("b2b.parity2", 2'b10, 1'b0, 1'b0, 1'b1);
        expect_cycle("b2b.stop2", 2'b11, 1'b0, 1'b0, 1'b1);
        expect_cycle("b2b.idle", 2'b11, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 4 of 5B (five ones, even parity 1).
        data = 8'h5B; par_en = 1'b1; par_type = 1'b0; valid = 1'b1;
        expect_cycle("rmid.start", 2'b00, 1'b0, 1'b1, 1'b1);
        valid = 1'b0;
        for (int i = 0; i < 5; i++) expect_cycle("rmid.data", 2'b01, data[i], 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid.sel", 32'(sel), 32'h3);
        check("rmid.busy", 32'(busy), 32'h0);
        check("rmid.ser", 32'(ser_bit), 32'h0);
        check("rmid.par", 32'(par_bit), 32'h0);
        check("rmid.state", 32'(state), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) expect_cycle("rmid.idle", 2'b11, 1'b0, 1'b0, 1'b0);
        check("rmid.par_after", 32'(par_bit), 32'h0);

        // Input stability: inputs change after bit 0, frame still carries FF with parity slot.
        data = 8'hFF; par_en = 1'b1; par_type = 1'b0; valid = 1'b1;
        expect_cycle("stab.start", 2'b00, 1'b0, 1'b0, 1'b1);
        valid = 1'b0;
        expect_cycle("stab.data", 2'b01, 1'b1, 1'b0, 1'b1);
        data = 8'h00; par_en = 1'b0; par_type = 1'b1;
        for (int i = 1; i < W; i++) expect_cycle("stab.data", 2'b01, 1'b1, 1'b0, 1'b1);
        expect_cycle("stab.parity", 2'b10, 1'b0, 1'b0, 1'b1);
        expect_cycle("stab.stop", 2'b11, 1'b0, 1'b0, 1'b1);
        expect_cycle("stab.idle", 2'b11, 1'b0, 1'b0, 1'b0);

`ifdef UART_TX_DOUBLE_BUFFER_EN
        // Second word during DATA fills the buffer; third word is dropped.
        data = 8'hA5; par_en = 1'b1; par_type = 1'b0; valid = 1'b1;
        expect_cycle("buf.start1", 2'b00, 1'b0, 1'b0, 1'b1);
        valid = 1'b0;
        expect_cycle("buf.data1", 2'b01, 1'b1, 1'b0, 1'b1);
        expect_cycle("buf.data1", 2'b01, 1'b0, 1'b0, 1'b1);
        data = 8'h3C; par_en = 1'b1; par_type = 1'b0; valid = 1'b1;
        expect_cycle("buf.data1", 2'b01, 1'b1, 1'b0, 1'b1);
        check("buf.full_set", 32'(buf_full), 32'h1);
        data = 8'hFF; par_en = 1'b0; par_type = 1'b1;
        expect_cycle("buf.data1", 2'b01, 1'b0, 1'b0, 1'b1);
        check("buf.full_hold", 32'(buf_full), 32'h1);
        valid = 1'b0;
        expect_cycle("buf.data1", 2'b01, 1'b0, 1'b0, 1'b1);
        expect_cycle("buf.data1", 2'b01, 1'b1, 1'b0, 1'b1);
        expect_cycle("buf.data1", 2'b01, 1'b0, 1'b0, 1'b1);
        expect_cycle("buf.data1", 2'b01, 1'b1, 1'b0, 1'b1);
        expect_cycle("buf.parity1", 2'b10, 1'b0, 1'b0, 1'b1);
        expect_cycle("buf.stop1", 2'b11, 1'b0, 1'b0, 1'b1);
        check("buf.full_stop", 32'(buf_full), 32'h1);
        expect_cycle("buf.start2", 2'b00, 1'b0, 1'b0, 1'b1);
        check("buf.full_clr", 32'(buf_full), 32'h0);
        data_bits("buf.data2", 8'h3C, 1'b0);
        expect_cycle("buf.parity2", 2'b10, 1'b0, 1'b0, 1'b1);
        expect_cycle("buf.stop2", 2'b11, 1'b0, 1'b0, 1'b1);
        expect_cycle("buf.idle", 2'b11, 1'b0, 1'b0, 1'b0);
        check("buf.full_idle", 32'(buf_full), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
